// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Moore-style sequencer for the multicycle RV32I datapath. Steps each
// instruction through fetch, decode, execute, memory and writeback, stalls
// memory states on MemReady and traps when a memory access exceeds
// WAIT_TIMEOUT consecutive waiting cycles. TRAP is left only through reset.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   Op, funct3,      instruction fields from the instruction register
//   funct7b5
//   Zero             ALU zero flag (branch resolution)
//   MemReady         memory completes the current access this cycle
//   PCWrite .. Trap  datapath control strobes and selects
//   State            current state code, for debug
module multicycle_control_unit #(
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter bit          SUPPORT_JAL  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Trap,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Counter only has to hold 0 .. WAIT_TIMEOUT-1.
    localparam int unsigned CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    alu_funct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is zero whenever a waiting state is entered: every path into
    // FETCH/MEMREAD/MEMWRITE either leaves a non-waiting state (which holds
    // it at zero) or completes an access (MemReady, which clears it).
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (MemReady) begin
                    unique case (state_q)
                        S_FETCH:   state_d = S_DECODE;
                        S_MEMREAD: state_d = S_MEMWB;
                        default:   state_d = S_FETCH;
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                unique case (Op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BEQ;
                    7'b1101111:             state_d = SUPPORT_JAL ? S_JAL : S_TRAP;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = Op[5] ? S_MEMWRITE : S_MEMREAD;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    always_comb begin
        unique case (funct3)
            3'b000:  alu_funct = ({Op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = ALU_ADD;
        RegWrite   = 1'b0;
        Trap       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = Op[5] ? 2'b01 : 2'b00;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                PCWrite    = Zero;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default:    Trap = 1'b1;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes the expected
// output vector of each cycle; a monitor pops and compares one per cycle.
// Two instances share inputs: dut (jal supported) and dut_nj (jal illegal).
module tb_multicycle_control_unit;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
        logic       rw, trap;
    } vec_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] alu;
    } alu_case_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] Op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b0;

    logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_trap;
    logic [1:0] a_rs, a_sa, a_sb, a_imm;
    logic [2:0] a_alu;
    logic [3:0] a_st;
    logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_trap;
    logic [1:0] b_rs, b_sa, b_sb, b_imm;
    logic [2:0] b_alu;
    logic [3:0] b_st;
    vec_t       act_a, act_b;

    vec_t  exp_q[$];
    bit    sel_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.WAIT_TIMEOUT(15), .SUPPORT_JAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(a_pcw), .AdrSrc(a_adr),
        .MemWrite(a_mw), .IRWrite(a_irw), .ResultSrc(a_rs), .ALUSrcA(a_sa),
        .ALUSrcB(a_sb), .ImmSrc(a_imm), .ALUControl(a_alu), .RegWrite(a_rw),
        .Trap(a_trap), .State(a_st)
    );

    multicycle_control_unit #(.WAIT_TIMEOUT(15), .SUPPORT_JAL(1'b0)) dut_nj (
        .clk(clk), .rst_n(rst_n), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(b_pcw), .AdrSrc(b_adr),
        .MemWrite(b_mw), .IRWrite(b_irw), .ResultSrc(b_rs), .ALUSrcA(b_sa),
        .ALUSrcB(b_sb), .ImmSrc(b_imm), .ALUControl(b_alu), .RegWrite(b_rw),
        .Trap(b_trap), .State(b_st)
    );

    assign act_a = {a_st, a_pcw, a_adr, a_mw, a_irw, a_rs, a_sa, a_sb, a_imm, a_alu, a_rw, a_trap};
    assign act_b = {b_st, b_pcw, b_adr, b_mw, b_irw, b_rs, b_sa, b_sb, b_imm, b_alu, b_rw, b_trap};

    // Expected outputs per state, straight from the state table.
    function automatic vec_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                                input logic mw, input logic irw, input logic [1:0] rs,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] imm, input logic [2:0] alu,
                                input logic rw, input logic trap);
        return {st, pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, trap};
    endfunction

    function automatic vec_t ex_f(input logic mr);
        return mk(4'd0, mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_d();
        return mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_ma(input logic sw);
        return mk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, sw ? 2'b01 : 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_mr();
        return mk(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_mwb();
        return mk(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    endfunction
    function automatic vec_t ex_mw();
        return mk(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_er(input logic [2:0] alu);
        return mk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_ei(input logic [2:0] alu);
        return mk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_awb();
        return mk(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    endfunction
    function automatic vec_t ex_j();
        return mk(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_b(input logic z);
        return mk(4'd10, z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0, 1'b0);
    endfunction
    function automatic vec_t ex_t();
        return mk(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
    endfunction

    // One cycle: inputs change on the falling edge, expectation queued for
    // the monitor, state advances on the following rising edge.
    task automatic step(input logic mr, input vec_t e, input string n, input bit sel = 1'b0);
        @(negedge clk);
        MemReady = mr;
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(n);
    endtask

    // Reset asserted mid-cycle and checked before the next rising edge; it is
    // released just after that edge so the wait counter starts from zero.
    task automatic do_reset(input string n);
        @(negedge clk);
        rst_n = 1'b0;
        MemReady = 1'b0;
        exp_q.push_back(ex_f(1'b0));
        sel_q.push_back(1'b0);
        name_q.push_back(n);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        vec_t  e, a;
        bit    s;
        string n;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                s = sel_q.pop_front();
                n = name_q.pop_front();
                a = s ? act_b : act_a;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got state=%0d vec=%h, want state=%0d vec=%h",
                             n, a.st, a, e.st, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    alu_case_t cases [8] = '{
        '{7'b0110011, 3'b000, 1'b1, 3'b001},
        '{7'b0110011, 3'b000, 1'b0, 3'b000},
        '{7'b0110011, 3'b010, 1'b0, 3'b101},
        '{7'b0110011, 3'b110, 1'b0, 3'b011},
        '{7'b0110011, 3'b111, 1'b0, 3'b010},
        '{7'b0010011, 3'b000, 1'b1, 3'b000},
        '{7'b0010011, 3'b001, 1'b0, 3'b000},
        '{7'b0010011, 3'b111, 1'b0, 3'b010}
    };

    initial begin : stimulus
        repeat (2) @(negedge clk);
        do_reset("reset");

        // lw, memory always ready
        Op = 7'b0000011;
        step(1'b1, ex_f(1'b1), "lw_fetch");
        step(1'b1, ex_d(),     "lw_decode");
        step(1'b1, ex_ma(1'b0), "lw_memadr");
        step(1'b1, ex_mr(),    "lw_memread");
        step(1'b1, ex_mwb(),   "lw_memwb");
        step(1'b0, ex_f(1'b0), "lw_back");

        // sw with three stall cycles
        do_reset("sw_reset");
        Op = 7'b0100011;
        step(1'b1, ex_f(1'b1), "sw_fetch");
        step(1'b0, ex_d(),     "sw_decode");
        step(1'b0, ex_ma(1'b1), "sw_memadr");
        for (int i = 0; i < 3; i++) step(1'b0, ex_mw(), "sw_stall");
        step(1'b1, ex_mw(),    "sw_done");
        step(1'b0, ex_f(1'b0), "sw_back");

        // reset during a stalled store
        do_reset("swab_reset");
        step(1'b1, ex_f(1'b1), "swab_fetch");
        step(1'b0, ex_d(),     "swab_decode");
        step(1'b0, ex_ma(1'b1), "swab_memadr");
        step(1'b0, ex_mw(),    "swab_memwrite");
        do_reset("swab_abort");
        step(1'b0, ex_f(1'b0), "swab_idle");

        // ALU decode
        foreach (cases[k]) begin
            do_reset("alu_reset");
            Op = cases[k].op;
            funct3 = cases[k].f3;
            funct7b5 = cases[k].f7;
            step(1'b1, ex_f(1'b1), "alu_fetch");
            step(1'b0, ex_d(), "alu_decode");
            if (cases[k].op[5]) step(1'b0, ex_er(cases[k].alu), "alu_execr");
            else                step(1'b0, ex_ei(cases[k].alu), "alu_execi");
            step(1'b0, ex_awb(), "alu_wb");
            step(1'b0, ex_f(1'b0), "alu_back");
        end
        funct3 = '0;
        funct7b5 = 1'b0;

        // beq taken and not taken
        for (int z = 0; z < 2; z++) begin
            do_reset("beq_reset");
            Op = 7'b1100011;
            Zero = z[0];
            step(1'b1, ex_f(1'b1), "beq_fetch");
            step(1'b0, ex_d(), "beq_decode");
            step(1'b0, ex_b(z[0]), "beq_exec");
            step(1'b0, ex_f(1'b0), "beq_back");
        end
        Zero = 1'b0;

        // jal supported
        do_reset("jal_reset");
        Op = 7'b1101111;
        step(1'b1, ex_f(1'b1), "jal_fetch");
        step(1'b0, ex_d(),     "jal_decode");
        step(1'b0, ex_j(),     "jal_jal");
        step(1'b0, ex_awb(),   "jal_wb");
        step(1'b0, ex_f(1'b0), "jal_back");

        // jal illegal when unsupported
        do_reset("nj_reset");
        step(1'b1, ex_f(1'b1), "nj_fetch", 1'b1);
        step(1'b0, ex_d(),     "nj_decode", 1'b1);
        step(1'b0, ex_t(),     "nj_trap", 1'b1);

        // fetch timeout, sticky trap, asynchronous exit
        do_reset("to_reset");
        Op = 7'b0000000;
        for (int i = 0; i < 15; i++) step(1'b0, ex_f(1'b0), "to_wait");
        step(1'b0, ex_t(), "to_trap");
        step(1'b1, ex_t(), "to_sticky");
        do_reset("to_exit");

        // ready on the timeout edge wins, then illegal opcode traps
        for (int i = 0; i < 14; i++) step(1'b0, ex_f(1'b0), "edge_wait");
        step(1'b1, ex_f(1'b1), "edge_ready");
        step(1'b0, ex_d(),     "ill_decode");
        step(1'b0, ex_t(),     "ill_trap");

        // memread timeout
        do_reset("mrto_reset");
        Op = 7'b0000011;
        step(1'b1, ex_f(1'b1), "mrto_fetch");
        step(1'b0, ex_d(),     "mrto_decode");
        step(1'b0, ex_ma(1'b0), "mrto_memadr");
        for (int i = 0; i < 15; i++) step(1'b0, ex_mr(), "mrto_wait");
        step(1'b0, ex_t(),     "mrto_trap");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM controller for the multicycle RV32I datapath; successor to the single-cycle decoder.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Stalls on a memory-ready handshake and traps on a memory timeout.
- Sits between the instruction register and the shared-memory multicycle datapath.

Parameters:
- WAIT_TIMEOUT, 15: maximum consecutive cycles a memory state may wait for MemReady before trapping; must be at least 1.
- SUPPORT_JAL, 1: 1 decodes jal (Op 1101111); 0 treats it as illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- Op  input  7  instruction opcode from IR
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RegWrite  output  1  register file write enable
- Trap  output  1  sticky; high while in TRAP
- State  output  4  current state, for debug

Behaviour:
- Reset: rst_n low asynchronously forces FETCH and clears the wait counter.
- Reset outputs (FETCH, MemReady=0): all zero except ALUSrcB=10 and ResultSrc=10. ALUControl=000, ImmSrc=00.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, JAL 9, BEQ 10, TRAP 15.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp add, ResultSrc=10.
  - IRWrite and PC update asserted only in the cycle MemReady=1; that cycle moves to DECODE. Otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add. Next state by Op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL if SUPPORT_JAL, else TRAP
  - any other -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=00 for lw, 01 for sw. Op[5]=0 -> MEMREAD, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits for MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every waiting cycle. MemReady -> FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, funct decode -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=Zero -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4).
- Funct decode:
  - funct3 000: sub if {Op[5],funct7b5}=11, else add
  - 010 slt, 110 or, 111 and
  - other funct3 values -> add
- Wait counter:
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE; increments each waiting cycle with MemReady=0.
  - When the count reaches WAIT_TIMEOUT with MemReady still 0, next state is TRAP.
  - MemReady=1 on the same edge as the timeout wins: access completes, no trap.
- TRAP: all enables 0, Trap=1. Exits only via reset.
- Reset mid-instruction: aborts the instruction with no further write strobes.
- Outputs are combinational from state and inputs; no output glitch requirements beyond a single clock domain.

Test Plan:
- Reset then MemReady held 1, Op=0000011 -> states 0,1,2,3,4,0. MemWB cycle has RegWrite=1, ResultSrc=01.
- sw with MemReady low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then FETCH. RegWrite never asserted.
- R-type with funct3=000, Op[5]=1, funct7b5=1 -> EXECR ALUControl=001. Same with funct7b5=0 -> 000. funct3=010/110/111 -> 101/011/010.
- beq with Zero=1 -> PCWrite=1 in BEQ. With Zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- FETCH with MemReady=0 for WAIT_TIMEOUT cycles -> State=15, Trap=1. rst_n pulse low -> State=0, Trap=0 immediately.
- Op=0000000 -> TRAP after DECODE. SUPPORT_JAL=0 with Op=1101111 -> TRAP. SUPPORT_JAL=1 -> JAL then ALUWB with PCWrite=1, then RegWrite=1.
